// File: rtl/mantissa_seq_p.sv
`default_nettype none
// ============================================================================
// Module   : mantissa_seq_p
// Purpose  : Multi-cycle mantissa aligner/adder/normaliser with word-serial
//            result output (most significant word first).
// Revision : 1.0 - initial release
// ============================================================================
module mantissa_seq_p #(
  parameter int MW = 64,
  parameter int OW = 32,
  parameter int AW = 8,
  parameter int EW = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [MW-1:0]           ma,
  input  logic [MW-1:0]           mb,
  input  logic [EW-1:0]           exp_diff,
  input  logic                    a_small,
  input  logic                    eff_sub,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [OW-1:0]           res_word,
  output logic                    res_last,
  output logic [$clog2(MW)+1:0]   exp_adj,
  output logic                    manzero,
  output logic                    res_swap
);

  localparam int          XW   = $clog2(MW) + 2;
  localparam int          NW   = MW / OW;
  localparam int          IW   = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [31:0] C_MW = 32'(MW);
  localparam logic [31:0] C_AW = 32'(AW);
  localparam logic [IW-1:0] C_LAST = IW'(NW - 1);
  localparam logic [XW-1:0] C_ONE  = {{(XW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALIGN = 3'd1,
    S_ADD   = 3'd2,
    S_NORM  = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [MW-1:0]   big_q, big_d;
  logic [MW-1:0]   small_q, small_d;
  logic [EW-1:0]   rem_q, rem_d;
  logic            sticky_q, sticky_d;
  logic            eff_sub_q, eff_sub_d;
  logic            swap_q, swap_d;
  logic [MW:0]     sum_q, sum_d;
  logic [XW-1:0]   exp_adj_q, exp_adj_d;
  logic            manzero_q, manzero_d;
  logic [IW-1:0]   word_idx_q, word_idx_d;

  logic [31:0]     rem_ext;
  logic [31:0]     shamt;

  assign rem_ext = 32'(rem_q);
  assign shamt   = (rem_ext < C_AW) ? rem_ext : C_AW;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      big_q      <= '0;
      small_q    <= '0;
      rem_q      <= '0;
      sticky_q   <= 1'b0;
      eff_sub_q  <= 1'b0;
      swap_q     <= 1'b0;
      sum_q      <= '0;
      exp_adj_q  <= '0;
      manzero_q  <= 1'b0;
      word_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      big_q      <= big_d;
      small_q    <= small_d;
      rem_q      <= rem_d;
      sticky_q   <= sticky_d;
      eff_sub_q  <= eff_sub_d;
      swap_q     <= swap_d;
      sum_q      <= sum_d;
      exp_adj_q  <= exp_adj_d;
      manzero_q  <= manzero_d;
      word_idx_q <= word_idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    big_d      = big_q;
    small_d    = small_q;
    rem_d      = rem_q;
    sticky_d   = sticky_q;
    eff_sub_d  = eff_sub_q;
    swap_d     = swap_q;
    sum_d      = sum_q;
    exp_adj_d  = exp_adj_q;
    manzero_d  = manzero_q;
    word_idx_d = word_idx_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          big_d      = a_small ? mb : ma;
          small_d    = a_small ? ma : mb;
          rem_d      = exp_diff;
          sticky_d   = 1'b0;
          eff_sub_d  = eff_sub;
          swap_d     = a_small;
          exp_adj_d  = '0;
          manzero_d  = 1'b0;
          word_idx_d = '0;
          state_d    = S_ALIGN;
        end
      end
      S_ALIGN: begin
        if (rem_ext >= C_MW) begin
          sticky_d = sticky_q | (|small_q);
          small_d  = '0;
          rem_d    = '0;
        end else begin
          sticky_d = sticky_q | (|(small_q & ~({MW{1'b1}} << shamt)));
          small_d  = small_q >> shamt;
          rem_d    = rem_q - EW'(shamt);
        end
        // Jam the accumulated sticky into the LSB on the final align cycle
        if (rem_d == '0) begin
          small_d[0] = small_d[0] | sticky_d;
          state_d    = S_ADD;
        end
      end
      S_ADD: begin
        sum_d   = eff_sub_q ? ({1'b0, big_q} - {1'b0, small_q})
                            : ({1'b0, big_q} + {1'b0, small_q});
        state_d = S_NORM;
      end
      S_NORM: begin
        if (sum_q[MW]) begin
          sum_d     = {1'b0, sum_q[MW:1]};
          sum_d[0]  = sum_q[1] | sum_q[0];
          exp_adj_d = C_ONE;
          state_d   = S_OUT;
        end else if (sum_q == '0) begin
          manzero_d = 1'b1;
          exp_adj_d = '0;
          state_d   = S_OUT;
        end else if (sum_q[MW-1]) begin
          state_d   = S_OUT;
        end else begin
          sum_d     = sum_q << 1;
          exp_adj_d = exp_adj_q - C_ONE;
        end
      end
      S_OUT: begin
        if (res_ready) begin
          if (word_idx_q == C_LAST) state_d = S_IDLE;
          else                      word_idx_d = word_idx_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    res_word = '0;
    for (int i = 0; i < NW; i++) begin
      if (state_q == S_OUT && word_idx_q == IW'(i)) res_word = sum_q[MW-1-i*OW -: OW];
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign res_valid = (state_q == S_OUT);
  assign res_last  = (state_q == S_OUT) && (word_idx_q == C_LAST);
  assign exp_adj   = exp_adj_q;
  assign manzero   = manzero_q;
  assign res_swap  = swap_q;

endmodule
`default_nettype wire

// File: tb/tb_mantissa_seq_p.sv
`default_nettype none
// ============================================================================
// Module   : tb_mantissa_seq_p
// Purpose  : Directed self-checking bench for mantissa_seq_p (MW=64, OW=32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mantissa_seq_p;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] ma, mb;
  logic [7:0]  exp_diff;
  logic        a_small, eff_sub;
  logic        res_valid, res_ready;
  logic [31:0] res_word;
  logic        res_last;
  logic [7:0]  exp_adj;
  logic        manzero, res_swap;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mantissa_seq_p #(.MW(64), .OW(32), .AW(8), .EW(8)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .ma(ma), .mb(mb), .exp_diff(exp_diff), .a_small(a_small), .eff_sub(eff_sub),
    .res_valid(res_valid), .res_ready(res_ready), .res_word(res_word),
    .res_last(res_last), .exp_adj(exp_adj), .manzero(manzero), .res_swap(res_swap)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Latency counts the accepting edge as edge 1, so the 1-align/1-norm case is 4.
  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic [7:0] ed, input logic asm, input logic sub,
                        input logic [31:0] w0, input logic [31:0] w1,
                        input logic [7:0] xadj, input logic mz, input int lat,
                        input int stall, input logic noise);
    int cnt;
    ma = a; mb = b; exp_diff = ed; a_small = asm; eff_sub = sub;
    req_valid = 1'b1;
    res_ready = (stall > 0) ? 1'b0 : 1'b1;
    @(posedge clk); #1;
    if (noise) begin
      ma = '1; mb = '1; exp_diff = 8'd3; a_small = ~asm; eff_sub = ~sub;
    end else begin
      req_valid = 1'b0;
    end
    cnt = 1;
    while (!res_valid && cnt < 60) begin
      @(posedge clk); #1;
      cnt++;
    end
    req_valid = 1'b0;
    check({tag, ".latency"}, 64'(cnt), 64'(lat));
    check({tag, ".busy"}, 64'(req_ready), 64'd0);
    for (int i = 0; i < stall; i++) begin
      check({tag, ".stall_w0"}, 64'(res_word), 64'(w0));
      check({tag, ".stall_valid"}, 64'(res_valid), 64'd1);
      check({tag, ".stall_side"}, {61'd0, res_last, manzero, res_swap}, {61'd0, 1'b0, mz, asm});
      check({tag, ".stall_adj"}, 64'(exp_adj), 64'(xadj));
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    check({tag, ".w0"}, 64'(res_word), 64'(w0));
    check({tag, ".last0"}, 64'(res_last), 64'd0);
    @(posedge clk); #1;
    check({tag, ".w1"}, 64'(res_word), 64'(w1));
    check({tag, ".last1"}, {62'd0, res_valid, res_last}, {62'd0, 2'b11});
    check({tag, ".adj"}, 64'(exp_adj), 64'(xadj));
    check({tag, ".manzero"}, 64'(manzero), 64'(mz));
    check({tag, ".swap"}, 64'(res_swap), 64'(asm));
    @(posedge clk); #1;
    check({tag, ".idle"}, {62'd0, req_ready, res_valid}, {62'd0, 2'b10});
  endtask

  initial begin
    int seen;
    reset = 1'b1; req_valid = 1'b0; res_ready = 1'b1;
    ma = '0; mb = '0; exp_diff = '0; a_small = 1'b0; eff_sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.ready", 64'(req_ready), 64'd1);
    check("rst.valid_last", {62'd0, res_valid, res_last}, 64'd0);
    check("rst.word", 64'(res_word), 64'd0);
    check("rst.adj", 64'(exp_adj), 64'd0);
    check("rst.mz_swap", {62'd0, manzero, res_swap}, 64'd0);
    reset = 1'b0;

    // Carry out of the adder, with 5 cycles of backpressure on word 0
    run_op("carry", 64'h8000000000000000, 64'h8000000000000000, 8'd0, 1'b0, 1'b0,
           32'h80000000, 32'h00000000, 8'h01, 1'b0, 4, 5, 1'b0);
    run_op("eqsub", 64'h123456789ABCDEF0, 64'h123456789ABCDEF0, 8'd0, 1'b0, 1'b1,
           32'h00000000, 32'h00000000, 8'h00, 1'b1, 4, 0, 1'b0);
    // req_valid held high with junk while busy must be ignored
    run_op("align3", 64'h8000000000000000, 64'h8000000000000001, 8'd20, 1'b1, 1'b0,
           32'h80000800, 32'h00000001, 8'h00, 1'b0, 6, 0, 1'b1);
    run_op("norm1", 64'h8000000000000000, 64'h4000000000000000, 8'd0, 1'b0, 1'b1,
           32'h80000000, 32'h00000000, 8'hFF, 1'b0, 5, 0, 1'b0);
    run_op("bigdiff", 64'h8000000000000000, 64'h0000000000000003, 8'd70, 1'b0, 1'b0,
           32'h80000000, 32'h00000001, 8'h00, 1'b0, 4, 0, 1'b0);
    run_op("sticky9", 64'h8000000000000000, 64'h00000000000000FF, 8'd9, 1'b0, 1'b0,
           32'h80000000, 32'h00000001, 8'h00, 1'b0, 5, 0, 1'b0);
    run_op("norm31", 64'h0000000100000000, 64'h0000000000000000, 8'd0, 1'b0, 1'b0,
           32'h80000000, 32'h00000000, 8'hE1, 1'b0, 35, 0, 1'b0);

    // Reset during ALIGN, then accept on the first edge after deassertion
    ma = 64'h8000000000000000; mb = 64'h8000000000000001; exp_diff = 8'd20;
    a_small = 1'b1; eff_sub = 1'b0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rstal.ready_valid", {62'd0, req_ready, res_valid}, {62'd0, 2'b10});
    run_op("postrst", 64'h8000000000000000, 64'h8000000000000000, 8'd0, 1'b0, 1'b0,
           32'h80000000, 32'h00000000, 8'h01, 1'b0, 4, 0, 1'b0);

    // Abandoned operation must emit no words
    ma = 64'h8000000000000000; mb = 64'h1; exp_diff = 8'd40;
    a_small = 1'b0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (res_valid) seen++;
      @(posedge clk); #1;
    end
    check("rstal.no_words", 64'(seen), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
